pll_reset_sequencer: RTL and testbench
======================================

// Module: pll_reset_sequencer
// PURPOSE
//  Supervises the system PLL and turns its lock status into clean, staggered, per-domain resets.
//  Runs on the free-running 50 MHz board reference clock.
//  Pulses the PLL reset and waits for a stable lock, retrying on timeout.
//  Releases NUM_DOMAINS reset outputs in order, e.g. SDRAM 143 MHz, SDRAM shifted clock, 1.5 MHz slow domain.
//  Sits directly downstream of the PLL; its pll_rst output closes the loop back to the PLL reset input.
// PARAMETERS
//  PLL_RST_CYCLES  16     cycles pll_rst is held high per attempt (>=1)
//  LOCK_TIMEOUT    50000  max cycles to reach STABLE_CYCLES of continuous lock per attempt (1 ms @ 50 MHz)
//  STABLE_CYCLES   1024   consecutive synchronised-lock cycles required before release (>=1)
//  NUM_DOMAINS     3      number of rst_out bits (1..8)
//  STAGGER_CYCLES  8      spacing between successive rst_out releases (>=1)
//  MAX_RETRIES     4      PLL re-reset attempts after the first before declaring failure
// PORTS
//  refclk      in   1            reference clock, free-running
//  rst         in   1            synchronous, active-high reset
//  pll_locked  in   1            PLL lock, asynchronous to refclk
//  pll_rst     out  1            reset to PLL, active high
//  rst_out     out  NUM_DOMAINS  per-domain resets, active high; bit i released i-th
//  ready       out  1            all domains released, lock stable
//  lock_fail   out  1            retries exhausted; sticky until rst
//  retry_cnt   out  3            attempts consumed in current acquisition
// BEHAVIOUR
//  Reset values (rst=1): pll_rst=1, rst_out=all 1, ready=0, lock_fail=0, retry_cnt=0, FSM=PLL_RST, all counters 0.
//  pll_locked passes through a 2-FF synchroniser (locked_s); 2 cycles of latency; nothing else samples raw pll_locked.
//  FSM states:
//   PLL_RST: pll_rst=1 for exactly PLL_RST_CYCLES cycles after entry, then -> WAIT_LOCK.
//   WAIT_LOCK: pll_rst=0. locked_s=1 -> STABLE.
//   STABLE: counts consecutive locked_s=1; locked_s=0 clears count and -> WAIT_LOCK; count==STABLE_CYCLES -> RELEASE.
//   Timeout: attempt timer runs across WAIT_LOCK+STABLE, cleared on PLL_RST entry. Reaching LOCK_TIMEOUT ->
//     retry_cnt<MAX_RETRIES: retry_cnt++, -> PLL_RST;  else -> FAIL.
//   RELEASE: rst_out[0] drops on entry; rst_out[i] drops i*STAGGER_CYCLES later; -> RUN when last bit drops.
//   RUN: ready=1, retry_cnt cleared.
//   FAIL: pll_rst=1, rst_out all 1, lock_fail=1; exits only on rst.
//  Latency: pll_locked rises (sampled at edge t) and stays high:
//   rst_out[0] falls at t+2+STABLE_CYCLES; rst_out[i] at that +i*STAGGER_CYCLES; ready rises with rst_out[N-1].
//  Lock loss in RELEASE or RUN (locked_s=0): next cycle all rst_out=1, ready=0, -> PLL_RST.
//   This does not consume a retry. Lock loss wins over a same-cycle final release.
//  Lock loss in STABLE does not re-pulse the PLL; only the timeout does.
//  Timeout and STABLE completion on the same cycle: completion wins.
//  rst asserted mid-sequence: all state returns to reset values on that edge.
//  rst_out never deasserts out of index order. All outputs are registered.
// CONFIGURATION
//  LOCK_LOSS_CNT_EN defined:
//   adds output lock_loss_cnt[7:0], counting RUN/RELEASE lock-loss events.
//   Saturates at 255; cleared only by rst.
//  Not defined: port and counter absent; all other behaviour identical.
// STRUCTURE
//  Shared package pll_rst_seq_pkg: FSM state encoding localparams (PLL_RST, WAIT_LOCK, STABLE, RELEASE, RUN, FAIL),
//   counter width helper (clog2 of max(LOCK_TIMEOUT, STABLE_CYCLES, NUM_DOMAINS*STAGGER_CYCLES)+1).
//  Sub-module sync_2ff: single-bit 2-flop synchroniser with reset value 0, reused by other CDC sites.
//  Single FSM + attempt timer + stable counter + stagger counter in the top module.
// TESTING (params: PLL_RST_CYCLES=4 LOCK_TIMEOUT=20 STABLE_CYCLES=8 NUM_DOMAINS=3 STAGGER_CYCLES=2 MAX_RETRIES=2)
//  Clean lock: rst released; pll_locked=1 at t=10, held.
//   Expect: pll_rst high 4 cycles; rst_out[0]=0 @t+10, [1] @t+12, [2] @t+14; ready=1 @t+14; retry_cnt=0.
//  Glitchy lock: pll_locked high 5 cycles, low 1, then high.
//   Expect: stable count restarts; rst_out[0] falls 10 cycles after the final rise.
//  No lock ever: expect 3 pll_rst pulses, retry_cnt 0->1->2, then lock_fail=1, pll_rst=1 steady, rst_out=3'b111.
//  Lock loss in RUN: drop pll_locked.
//   Expect: 3 cycles later rst_out=3'b111, ready=0, pll_rst=1 for 4 cycles; relock rereleases; lock_loss_cnt=1 if enabled.
//  Lock loss during RELEASE, after rst_out[0] fell: expect all bits back to 1, no out-of-order release.
//  rst pulsed in RUN and in FAIL: expect exact reset values next cycle, lock_fail cleared, full sequence repeats.

Source files
------------

// File: rtl/pll_rst_seq_pkg.sv
// Shared definitions for the PLL reset sequencer.
//   state_t    : sequencer FSM encoding
//   cnt_width  : width needed to hold the largest counter terminal value
package pll_rst_seq_pkg;

    typedef enum logic [2:0] {
        PLL_RST   = 3'd0,
        WAIT_LOCK = 3'd1,
        STABLE    = 3'd2,
        RELEASE   = 3'd3,
        RUN       = 3'd4,
        FAIL      = 3'd5
    } state_t;

    // clog2(max(a, b, c) + 1)
    function automatic int cnt_width(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Single-bit two-flop synchroniser, reset value 0.
//   i_clk : destination clock
//   i_rst : synchronous active-high reset
//   i_d   : asynchronous input
//   o_q   : synchronised output, 2 cycles of latency
module sync_2ff (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/pll_reset_sequencer.sv
// PLL supervisor: pulses the PLL reset, waits for a stable lock (retrying on
// timeout), then releases the per-domain resets one after another.
// Optional feature macro: LOCK_LOSS_CNT_EN adds o_lock_loss_cnt.
//   i_refclk        : free-running reference clock
//   i_rst           : synchronous active-high reset
//   i_pll_locked    : PLL lock, asynchronous to i_refclk
//   o_lock_loss_cnt : (LOCK_LOSS_CNT_EN) saturating count of RELEASE/RUN lock losses
//   o_pll_rst       : reset to the PLL, active high
//   o_rst_out       : per-domain resets, active high, bit i released i-th
//   o_ready         : all domains released with lock stable
//   o_lock_fail     : retries exhausted, sticky until i_rst
//   o_retry_cnt     : retries consumed in the current acquisition
module pll_reset_sequencer
    import pll_rst_seq_pkg::*;
#(
    parameter int PLL_RST_CYCLES = 16,
    parameter int LOCK_TIMEOUT   = 50000,
    parameter int STABLE_CYCLES  = 1024,
    parameter int NUM_DOMAINS    = 3,
    parameter int STAGGER_CYCLES = 8,
    parameter int MAX_RETRIES    = 4
) (
    input  logic                   i_refclk,
    input  logic                   i_rst,
    input  logic                   i_pll_locked,
`ifdef LOCK_LOSS_CNT_EN
    output logic [7:0]             o_lock_loss_cnt,
`endif
    output logic                   o_pll_rst,
    output logic [NUM_DOMAINS-1:0] o_rst_out,
    output logic                   o_ready,
    output logic                   o_lock_fail,
    output logic [2:0]             o_retry_cnt
);

    // One width covers the attempt timer, stable counter and the shared
    // PLL-reset/stagger counter.
    localparam int CW = cnt_width((LOCK_TIMEOUT > PLL_RST_CYCLES) ? LOCK_TIMEOUT : PLL_RST_CYCLES,
                                  STABLE_CYCLES, NUM_DOMAINS * STAGGER_CYCLES);

    localparam logic [CW-1:0]          C_PRST  = CW'(PLL_RST_CYCLES - 1);
    localparam logic [CW-1:0]          C_TMO   = CW'(LOCK_TIMEOUT - 1);
    localparam logic [CW-1:0]          C_STB   = CW'(STABLE_CYCLES - 1);
    localparam logic [2:0]             C_MAXR  = 3'(MAX_RETRIES);
    // Reset pattern on entry to RELEASE: only bit 0 released.
    localparam logic [NUM_DOMAINS-1:0] C_FIRST = ~(NUM_DOMAINS'(1));

    state_t                  r_state, w_state;
    logic [CW-1:0]           r_cnt, w_cnt;     // PLL_RST hold count / RELEASE stagger count
    logic [CW-1:0]           r_tmr, w_tmr;     // attempt timer over WAIT_LOCK+STABLE
    logic [CW-1:0]           r_stb, w_stb;     // consecutive-lock count
    logic                    r_pll_rst, w_pll_rst;
    logic [NUM_DOMAINS-1:0]  r_rst_out, w_rst_out;
    logic                    r_ready, w_ready;
    logic                    r_lock_fail, w_lock_fail;
    logic [2:0]              r_retry, w_retry;

    logic                    w_locked_s;
    logic [CW-1:0]           w_stg;
    logic [NUM_DOMAINS-1:0]  w_rel_mask;

    sync_2ff u_lock_sync (
        .i_clk (i_refclk),
        .i_rst (i_rst),
        .i_d   (i_pll_locked),
        .o_q   (w_locked_s)
    );

    // Bit i stays in reset until the stagger count reaches i*STAGGER_CYCLES;
    // the mask is monotone in the count so release order is preserved.
    always_comb begin
        w_stg      = r_cnt + CW'(1);
        w_rel_mask = '1;
        for (int i = 0; i < NUM_DOMAINS; i++) begin
            if (w_stg >= CW'(i * STAGGER_CYCLES)) w_rel_mask[i] = 1'b0;
        end
    end

    always_ff @(posedge i_refclk) begin
        if (i_rst) begin
            r_state     <= PLL_RST;
            r_cnt       <= '0;
            r_tmr       <= '0;
            r_stb       <= '0;
            r_pll_rst   <= 1'b1;
            r_rst_out   <= '1;
            r_ready     <= 1'b0;
            r_lock_fail <= 1'b0;
            r_retry     <= 3'd0;
        end else begin
            r_state     <= w_state;
            r_cnt       <= w_cnt;
            r_tmr       <= w_tmr;
            r_stb       <= w_stb;
            r_pll_rst   <= w_pll_rst;
            r_rst_out   <= w_rst_out;
            r_ready     <= w_ready;
            r_lock_fail <= w_lock_fail;
            r_retry     <= w_retry;
        end
    end

    always_comb begin
        w_state     = r_state;
        w_cnt       = r_cnt;
        w_tmr       = r_tmr;
        w_stb       = r_stb;
        w_pll_rst   = r_pll_rst;
        w_rst_out   = r_rst_out;
        w_ready     = r_ready;
        w_lock_fail = r_lock_fail;
        w_retry     = r_retry;

        case (r_state)
            PLL_RST: begin
                w_pll_rst = 1'b1;
                w_tmr     = '0;
                w_stb     = '0;
                if (r_cnt == C_PRST) begin
                    w_state   = WAIT_LOCK;
                    w_pll_rst = 1'b0;
                    w_cnt     = '0;
                end else begin
                    w_cnt = r_cnt + CW'(1);
                end
            end

            WAIT_LOCK, STABLE: begin
                w_tmr = r_tmr + CW'(1);
                // Completion outranks a same-cycle timeout.
                if (r_state == STABLE && w_locked_s && r_stb == C_STB) begin
                    w_cnt     = '0;
                    w_rst_out = C_FIRST;
                    if (!C_FIRST[NUM_DOMAINS-1]) begin
                        w_state = RUN;
                        w_ready = 1'b1;
                        w_retry = 3'd0;
                    end else begin
                        w_state = RELEASE;
                    end
                end else if (r_tmr == C_TMO) begin
                    if (r_retry < C_MAXR) begin
                        w_retry   = r_retry + 3'd1;
                        w_state   = PLL_RST;
                        w_pll_rst = 1'b1;
                        w_cnt     = '0;
                        w_tmr     = '0;
                        w_stb     = '0;
                    end else begin
                        w_state     = FAIL;
                        w_pll_rst   = 1'b1;
                        w_lock_fail = 1'b1;
                        w_rst_out   = '1;
                    end
                end else if (!w_locked_s) begin
                    // Lock dropout while qualifying: restart the count, keep the timer.
                    w_state = WAIT_LOCK;
                    w_stb   = '0;
                end else if (r_state == WAIT_LOCK) begin
                    w_state = STABLE;
                    w_stb   = '0;
                end else begin
                    w_stb = r_stb + CW'(1);
                end
            end

            RELEASE, RUN: begin
                // Lock loss beats a same-cycle final release and costs no retry.
                if (!w_locked_s) begin
                    w_state   = PLL_RST;
                    w_cnt     = '0;
                    w_tmr     = '0;
                    w_pll_rst = 1'b1;
                    w_rst_out = '1;
                    w_ready   = 1'b0;
                end else if (r_state == RELEASE) begin
                    w_cnt     = w_stg;
                    w_rst_out = w_rel_mask;
                    if (!w_rel_mask[NUM_DOMAINS-1]) begin
                        w_state = RUN;
                        w_ready = 1'b1;
                        w_retry = 3'd0;
                    end
                end
            end

            FAIL: begin
                w_pll_rst   = 1'b1;
                w_rst_out   = '1;
                w_lock_fail = 1'b1;
            end

            default: begin
                w_state   = PLL_RST;
                w_cnt     = '0;
                w_pll_rst = 1'b1;
                w_rst_out = '1;
                w_ready   = 1'b0;
            end
        endcase
    end

`ifdef LOCK_LOSS_CNT_EN
    logic       w_loss;
    logic [7:0] r_llc;

    assign w_loss = (r_state == RELEASE || r_state == RUN) && !w_locked_s;

    always_ff @(posedge i_refclk) begin
        if (i_rst)                          r_llc <= 8'd0;
        else if (w_loss && r_llc != 8'hFF)  r_llc <= r_llc + 8'd1;
    end

    assign o_lock_loss_cnt = r_llc;
`endif

    assign o_pll_rst   = r_pll_rst;
    assign o_rst_out   = r_rst_out;
    assign o_ready     = r_ready;
    assign o_lock_fail = r_lock_fail;
    assign o_retry_cnt = r_retry;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Self-checking bench for pll_reset_sequencer with small timing parameters.
// Cycle n = the n-th rising edge after the reset edge (edge 0); inputs are
// applied before edge n and outputs sampled 1 time unit after it.
module tb_pll_reset_sequencer;

    localparam int P  = 4;
    localparam int T  = 20;
    localparam int S  = 8;
    localparam int N  = 3;
    localparam int ST = 2;
    localparam int MR = 2;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         lk  = 1'b0;
    logic         pll_rst;
    logic [N-1:0] rst_out;
    logic         ready;
    logic         lock_fail;
    logic [2:0]   retry_cnt;
`ifdef LOCK_LOSS_CNT_EN
    logic [7:0]   llc;
`endif

    pll_reset_sequencer #(
        .PLL_RST_CYCLES (P),
        .LOCK_TIMEOUT   (T),
        .STABLE_CYCLES  (S),
        .NUM_DOMAINS    (N),
        .STAGGER_CYCLES (ST),
        .MAX_RETRIES    (MR)
    ) dut (
        .i_refclk        (clk),
        .i_rst           (rst),
        .i_pll_locked    (lk),
`ifdef LOCK_LOSS_CNT_EN
        .o_lock_loss_cnt (llc),
`endif
        .o_pll_rst       (pll_rst),
        .o_rst_out       (rst_out),
        .o_ready         (ready),
        .o_lock_fail     (lock_fail),
        .o_retry_cnt     (retry_cnt)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    typedef struct {
        int         n;
        logic       r;
        logic       l;
        logic       prst;
        logic [2:0] ro;
        logic       rdy;
        logic       lf;
        logic [2:0] rc;
    } vec_t;

    vec_t tbl[13];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk_outs(input string name, input logic prst, input logic [2:0] ro,
                            input logic rdy, input logic lf, input logic [2:0] rc);
        chk({name, ".pll_rst"},   32'(pll_rst),   32'(prst));
        chk({name, ".rst_out"},   32'(rst_out),   32'(ro));
        chk({name, ".ready"},     32'(ready),     32'(rdy));
        chk({name, ".lock_fail"}, 32'(lock_fail), 32'(lf));
        chk({name, ".retry_cnt"}, 32'(retry_cnt), 32'(rc));
    endtask

    // rst_out must always be a thermometer released from bit 0 upward.
    task automatic tick(input logic r, input logic l);
        logic ordered;
        rst = r;
        lk  = l;
        @(posedge clk);
        #1;
        ordered = (rst_out == 3'b111) || (rst_out == 3'b110) ||
                  (rst_out == 3'b100) || (rst_out == 3'b000);
        chk("order", 32'(ordered), 32'd1);
    endtask

    task automatic run(input logic r, input logic l, input int n);
        for (int k = 0; k < n; k++) tick(r, l);
    endtask

    task automatic run_table();
        for (int i = 0; i < 13; i++) begin
            for (int j = 0; j < tbl[i].n; j++) begin
                tick(tbl[i].r, tbl[i].l);
                chk_outs($sformatf("vec%0d.%0d", i, j), tbl[i].prst, tbl[i].ro,
                         tbl[i].rdy, tbl[i].lf, tbl[i].rc);
            end
        end
    endtask

    initial begin
        int   falls;
        logic prev;

        // Clean lock (lock sampled at edge 10), lock loss in RUN, relock at edge 35.
        tbl[0]  = '{1,  1'b1, 1'b0, 1'b1, 3'b111, 1'b0, 1'b0, 3'd0}; // edge 0 reset
        tbl[1]  = '{3,  1'b0, 1'b0, 1'b1, 3'b111, 1'b0, 1'b0, 3'd0}; // 1-3
        tbl[2]  = '{6,  1'b0, 1'b0, 1'b0, 3'b111, 1'b0, 1'b0, 3'd0}; // 4-9
        tbl[3]  = '{10, 1'b0, 1'b1, 1'b0, 3'b111, 1'b0, 1'b0, 3'd0}; // 10-19
        tbl[4]  = '{2,  1'b0, 1'b1, 1'b0, 3'b110, 1'b0, 1'b0, 3'd0}; // 20-21
        tbl[5]  = '{2,  1'b0, 1'b1, 1'b0, 3'b100, 1'b0, 1'b0, 3'd0}; // 22-23
        tbl[6]  = '{5,  1'b0, 1'b1, 1'b0, 3'b000, 1'b1, 1'b0, 3'd0}; // 24-28
        tbl[7]  = '{2,  1'b0, 1'b0, 1'b0, 3'b000, 1'b1, 1'b0, 3'd0}; // 29-30
        tbl[8]  = '{4,  1'b0, 1'b0, 1'b1, 3'b111, 1'b0, 1'b0, 3'd0}; // 31-34
        tbl[9]  = '{10, 1'b0, 1'b1, 1'b0, 3'b111, 1'b0, 1'b0, 3'd0}; // 35-44
        tbl[10] = '{2,  1'b0, 1'b1, 1'b0, 3'b110, 1'b0, 1'b0, 3'd0}; // 45-46
        tbl[11] = '{2,  1'b0, 1'b1, 1'b0, 3'b100, 1'b0, 1'b0, 3'd0}; // 47-48
        tbl[12] = '{3,  1'b0, 1'b1, 1'b0, 3'b000, 1'b1, 1'b0, 3'd0}; // 49-51

        run_table();
`ifdef LOCK_LOSS_CNT_EN
        chk("llc_after_run_loss", 32'(llc), 32'd1);
`endif

        // rst in RUN
        tick(1'b1, 1'b1);
        chk_outs("rst_in_run", 1'b1, 3'b111, 1'b0, 1'b0, 3'd0);

        // Glitchy lock: high 6-10, low 11, high from 12 -> release at 22
        tick(1'b1, 1'b0);
        run(1'b0, 1'b0, 5);
        run(1'b0, 1'b1, 5);
        tick(1'b0, 1'b0);
        for (int e = 12; e <= 21; e++) begin
            tick(1'b0, 1'b1);
            chk($sformatf("glitch_hold%0d", e), 32'(rst_out), 32'h7);
        end
        tick(1'b0, 1'b1);
        chk("glitch_rel0", 32'(rst_out), 32'h6);
        run(1'b0, 1'b1, 4);
        chk_outs("glitch_run", 1'b0, 3'b000, 1'b1, 1'b0, 3'd0);

        // Timeout and completion on the same edge (24): completion wins
        tick(1'b1, 1'b0);
        run(1'b0, 1'b0, 13);
        run(1'b0, 1'b1, 10);
        chk_outs("tmo_pre", 1'b0, 3'b111, 1'b0, 1'b0, 3'd0);
        tick(1'b0, 1'b1);
        chk_outs("tmo_vs_done", 1'b0, 3'b110, 1'b0, 1'b0, 3'd0);
        run(1'b0, 1'b1, 4);
        chk_outs("tmo_vs_done_run", 1'b0, 3'b000, 1'b1, 1'b0, 3'd0);

        // One retry then lock (sampled at 30): retry_cnt 1 until RUN at 44
        tick(1'b1, 1'b0);
        run(1'b0, 1'b0, 29);
        run(1'b0, 1'b1, 14);
        chk_outs("retry_rel", 1'b0, 3'b100, 1'b0, 1'b0, 3'd1);
        tick(1'b0, 1'b1);
        chk_outs("retry_run", 1'b0, 3'b000, 1'b1, 1'b0, 3'd0);

        // Lock loss during RELEASE after bit 0 fell (release at 15, loss seen at 17)
        tick(1'b1, 1'b0);
        run(1'b0, 1'b0, 4);
        run(1'b0, 1'b1, 10);
        tick(1'b0, 1'b0);
        chk("rel_loss15", 32'(rst_out), 32'h6);
        tick(1'b0, 1'b0);
        chk("rel_loss16", 32'(rst_out), 32'h6);
        tick(1'b0, 1'b0);
        chk_outs("rel_loss17", 1'b1, 3'b111, 1'b0, 1'b0, 3'd0);
`ifdef LOCK_LOSS_CNT_EN
        chk("llc_after_rel_loss", 32'(llc), 32'd1);
`endif

        // Lock loss on the same edge as final release (19): loss wins
        tick(1'b1, 1'b0);
        run(1'b0, 1'b0, 4);
        run(1'b0, 1'b1, 12);
        tick(1'b0, 1'b0);
        chk("col17", 32'(rst_out), 32'h4);
        tick(1'b0, 1'b0);
        chk("col18", 32'(rst_out), 32'h4);
        tick(1'b0, 1'b0);
        chk_outs("col19", 1'b1, 3'b111, 1'b0, 1'b0, 3'd0);

        // No lock ever: timeouts at 24, 48, FAIL at 72
        tick(1'b1, 1'b0);
        falls = 0;
        prev  = pll_rst;
        for (int e = 1; e <= 100; e++) begin
            tick(1'b0, 1'b0);
            if (prev && !pll_rst) falls++;
            prev = pll_rst;
            if (e == 23) chk_outs("nl23", 1'b0, 3'b111, 1'b0, 1'b0, 3'd0);
            if (e == 24) chk_outs("nl24", 1'b1, 3'b111, 1'b0, 1'b0, 3'd1);
            if (e == 48) chk_outs("nl48", 1'b1, 3'b111, 1'b0, 1'b0, 3'd2);
            if (e == 71) chk_outs("nl71", 1'b0, 3'b111, 1'b0, 1'b0, 3'd2);
            if (e == 72) chk_outs("nl72", 1'b1, 3'b111, 1'b0, 1'b1, 3'd2);
        end
        chk("nl_pulses", 32'(falls), 32'd3);
        chk_outs("nl_fail", 1'b1, 3'b111, 1'b0, 1'b1, 3'd2);
        run(1'b0, 1'b1, 20);
        chk_outs("fail_sticky", 1'b1, 3'b111, 1'b0, 1'b1, 3'd2);

        // rst in FAIL, then the full sequence again
        tick(1'b1, 1'b1);
        chk_outs("rst_in_fail", 1'b1, 3'b111, 1'b0, 1'b0, 3'd0);
        run_table();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
